fpu_invsqrt_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined floating-point inverse-square-root unit among N requesters in the gravity engine, for example per-body force calculators that need 1/sqrt(r²). It issues at most one operand per clock to the external pipe and tracks each in-flight operation with a requester tag. It returns each result to the requester that issued it, with a one-cycle done pulse. A requester may have only one operation outstanding at a time.

---
 rtl/fpu_invsqrt_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpu_invsqrt_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_invsqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_invsqrt_arbiter
// Purpose  : Round-robin sharing of one pipelined FP inverse-square-root unit
//            among N requesters. Issues at most one operand per clock, tags
//            each operation with its requester index, and routes the result
//            back with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
module fpu_invsqrt_arbiter #(
    parameter int N        = 4,
    parameter int PIPE_LAT = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [N-1:0]      iReq,
    input  logic [32*N-1:0]   iOperand,
    output logic [N-1:0]      oGrant,
    output logic [31:0]       oPipeA,
    input  logic [31:0]       iPipeResult,
    output logic [31:0]       oResult,
    output logic [N-1:0]      oDone,
    output logic [N-1:0]      oPending,
    output logic              oBusy
);

    // Requester count widened by one bit so index sums can be wrapped without overflow.
    localparam logic [IDX_W:0] c_n = (IDX_W+1)'(N);

    // Issue register
    logic                 issue_vld_q, issue_vld_d;
    logic [IDX_W-1:0]     issue_idx_q, issue_idx_d;
    logic [31:0]          issue_op_q,  issue_op_d;

    // Tag shift register tracking in-flight operations alongside the pipe
    logic [PIPE_LAT-1:0]  tag_vld_q, tag_vld_d;
    logic [IDX_W-1:0]     tag_idx_q [PIPE_LAT];
    logic [IDX_W-1:0]     tag_idx_d [PIPE_LAT];

    // Arbitration and per-requester bookkeeping
    logic [IDX_W-1:0]     rr_ptr_q,  rr_ptr_d;
    logic [N-1:0]         grant_q,   grant_d;
    logic [N-1:0]         done_q,    done_d;
    logic [N-1:0]         pending_q, pending_d;
    logic [31:0]          result_q,  result_d;

    // Combinational helpers
    logic [N-1:0]         w_elig;
    logic                 w_win_vld;
    logic [IDX_W-1:0]     w_win_idx;
    logic [IDX_W:0]       w_cand;
    logic [IDX_W:0]       w_rr_nxt;
    logic                 w_ret_vld;
    logic [IDX_W-1:0]     w_ret_idx;

    // Pick the first eligible requester scanning upward from rr_ptr with wrap.
    // Eligibility uses the registered pending bits, so a requester retiring on
    // this edge cannot be re-granted on the same edge.
    always_comb begin
        w_elig    = iReq & ~pending_q;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (w_cand >= c_n) begin
                w_cand = w_cand - c_n;
            end
            if (!w_win_vld && w_elig[w_cand[IDX_W-1:0]]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand[IDX_W-1:0];
            end
        end
    end

    // Issue register, grant pulse and round-robin pointer update.
    always_comb begin
        issue_vld_d = w_win_vld;
        issue_idx_d = w_win_idx;
        issue_op_d  = w_win_vld ? iOperand[{w_win_idx, 5'b00000} +: 32] : issue_op_q;
        grant_d     = '0;
        w_rr_nxt    = {1'b0, w_win_idx} + {{IDX_W{1'b0}}, 1'b1};
        if (w_rr_nxt >= c_n) begin
            w_rr_nxt = '0;
        end
        rr_ptr_d    = rr_ptr_q;
        if (w_win_vld) begin
            grant_d[w_win_idx] = 1'b1;
            rr_ptr_d           = w_rr_nxt[IDX_W-1:0];
        end
    end

    // Tag pipeline: entry 0 follows the issue register, last entry lines up with iPipeResult.
    always_comb begin
        tag_vld_d[0] = issue_vld_q;
        tag_idx_d[0] = issue_idx_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
    end

    // Retire: capture the pipe result, pulse done, and release the requester.
    always_comb begin
        w_ret_vld = tag_vld_q[PIPE_LAT-1];
        w_ret_idx = tag_idx_q[PIPE_LAT-1];
        done_d    = '0;
        result_d  = result_q;
        if (w_ret_vld) begin
            done_d[w_ret_idx] = 1'b1;
            result_d          = iPipeResult;
        end
        pending_d = (pending_q & ~done_d) | grant_d;
    end

    // State registers with synchronous active-low reset; in-flight work is discarded.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            issue_vld_q <= 1'b0;
            issue_idx_q <= '0;
            issue_op_q  <= 32'h0;
            tag_vld_q   <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            pending_q   <= '0;
            result_q    <= 32'h0;
        end else begin
            issue_vld_q <= issue_vld_d;
            issue_idx_q <= issue_idx_d;
            issue_op_q  <= issue_op_d;
            tag_vld_q   <= tag_vld_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_idx_q[i] <= tag_idx_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            pending_q   <= pending_d;
            result_q    <= result_d;
        end
    end

    assign oGrant   = grant_q;
    assign oPipeA   = issue_vld_q ? issue_op_q : 32'h0;
    assign oResult  = result_q;
    assign oDone    = done_q;
    assign oPending = pending_q;
    assign oBusy    = issue_vld_q | (|tag_vld_q);

endmodule
`default_nettype wire

// File: tb/tb_fpu_invsqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_invsqrt_arbiter
// Purpose  : Self-checking bench for fpu_invsqrt_arbiter with a stub invsqrt
//            pipe and a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpu_invsqrt_arbiter;

    localparam int N        = 4;
    localparam int PIPE_LAT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [32*N-1:0]   operand;
    logic [N-1:0]      grant;
    logic [31:0]       pipe_a;
    logic [31:0]       pipe_res;
    logic [31:0]       result;
    logic [N-1:0]      done;
    logic [N-1:0]      pending;
    logic              busy;

    int checks = 0;
    int errors = 0;

    fpu_invsqrt_arbiter #(.N(N), .PIPE_LAT(PIPE_LAT)) dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iReq        (req),
        .iOperand    (operand),
        .oGrant      (grant),
        .oPipeA      (pipe_a),
        .iPipeResult (pipe_res),
        .oResult     (result),
        .oDone       (done),
        .oPending    (pending),
        .oBusy       (busy)
    );

    always #5 clk = ~clk;

    // Stub invsqrt: exact for positive powers of four, a fixed bit-mix otherwise.
    function automatic logic [31:0] pipe_fn(input logic [31:0] x);
        int e;
        e = int'(x[30:23]);
        if (!x[31] && x[22:0] == 23'd0 && e >= 1 && e <= 253 && ((e - 127) % 2) == 0)
            return {1'b0, 8'(127 - (e - 127) / 2), 23'd0};
        return {x[15:0], x[31:16]} ^ 32'h5F37_59DF;
    endfunction

    // Pipe stub with PIPE_LAT edges of latency.
    logic [31:0] pipe_sr [PIPE_LAT];
    always @(posedge clk) begin
        pipe_sr[0] <= pipe_fn(pipe_a);
        for (int k = 1; k < PIPE_LAT; k++) pipe_sr[k] <= pipe_sr[k-1];
    end
    assign pipe_res = pipe_sr[PIPE_LAT-1];

    // Reference model state
    typedef struct {
        int          idx;
        logic [31:0] op;
        int          ret;
    } fl_t;
    fl_t          inflight[$];
    logic [N-1:0] m_pend;
    int           m_rr;
    int           edge_cnt = 0;
    logic [N-1:0] e_grant, e_done;
    logic [31:0]  e_result, e_pipea;
    logic         e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs sampled at that edge.
    task automatic model_edge();
        logic [N-1:0] elig;
        fl_t          f;
        edge_cnt++;
        if (!rst_n) begin
            inflight.delete();
            m_pend   = '0;
            m_rr     = 0;
            e_grant  = '0;
            e_done   = '0;
            e_result = 32'h0;
            e_pipea  = 32'h0;
        end else begin
            elig    = req & ~m_pend;
            e_done  = '0;
            for (int i = inflight.size() - 1; i >= 0; i--) begin
                if (inflight[i].ret == edge_cnt) begin
                    e_done[inflight[i].idx] = 1'b1;
                    e_result                = pipe_fn(inflight[i].op);
                    m_pend[inflight[i].idx] = 1'b0;
                    inflight.delete(i);
                end
            end
            e_grant = '0;
            e_pipea = 32'h0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_rr + i) % N;
                if (e_grant == '0 && elig[k]) begin
                    e_grant[k] = 1'b1;
                    e_pipea    = operand[32*k +: 32];
                    m_pend[k]  = 1'b1;
                    m_rr       = (k + 1) % N;
                    f.idx = k;
                    f.op  = operand[32*k +: 32];
                    f.ret = edge_cnt + PIPE_LAT + 1;
                    inflight.push_back(f);
                end
            end
        end
        e_busy = (inflight.size() != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("grant",   32'(grant),   32'(e_grant));
        chk("done",    32'(done),    32'(e_done));
        chk("result",  result,       e_result);
        chk("pending", 32'(pending), 32'(m_pend));
        chk("busy",    32'(busy),    32'(e_busy));
        chk("pipea",   pipe_a,       e_pipea);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'h8000_0000 | 32'($urandom);
            2:       return {1'b0, 8'(127 + 2 * $urandom_range(0, 20) - 20), 23'd0};
            default: return 32'($urandom);
        endcase
    endfunction

    logic [N-1:0] hold;

    initial begin
        // Reset held with all requesting
        rst_n   = 1'b0;
        req     = 4'b1111;
        operand = {32'h4280_0000, 32'h4180_0000, 32'h4080_0000, 32'h3F80_0000};
        repeat (3) tick();

        // Single operation on requester 2
        rst_n = 1'b1;
        req   = '0;
        repeat (2) tick();
        req = 4'b0100;
        operand[64 +: 32] = 32'h4080_0000;
        tick();
        chk("sgl_grant", 32'(grant), 32'h4);
        chk("sgl_pipea", pipe_a, 32'h4080_0000);
        req = '0;
        repeat (4) tick();
        tick();
        chk("sgl_done",   32'(done), 32'h4);
        chk("sgl_result", result,    32'h3F00_0000);

        // Round robin from rr_ptr=0 with all four requesting continuously
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        req     = 4'b1111;
        operand = {32'h4280_0000, 32'h4180_0000, 32'h4080_0000, 32'h3F80_0000};
        for (int i = 0; i < N; i++) begin
            tick();
            chk("rr_order", 32'(grant), 32'(1 << i));
        end
        repeat (14) tick();
        req = '0;
        repeat (7) tick();

        // Fairness: pointer left at 3, then 0 and 3 request together
        req = 4'b0100;
        tick();
        req = 4'b1001;
        tick();
        chk("fair_first", 32'(grant), 32'h8);
        req = 4'b0001;
        tick();
        chk("fair_second", 32'(grant), 32'h1);
        req = '0;
        repeat (7) tick();

        // Retire/re-issue collision: grant, done 5 edges later, re-grant one edge after done
        req = 4'b0010;
        operand[32 +: 32] = 32'h4180_0000;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk("coll_grant", 32'(grant[1]), 32'(i % 6 == 0));
            chk("coll_done",  32'(done[1]),  32'(i % 6 == 5));
        end
        req = '0;
        repeat (7) tick();

        // Reset two edges after a grant
        req = 4'b0001;
        operand[0 +: 32] = 32'h4080_0000;
        tick();
        req = '0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_pending", 32'(pending), 32'h0);
        chk("mid_busy",    32'(busy),    32'h0);
        rst_n = 1'b1;
        repeat (7) tick();
        req = 4'b0100;
        operand[64 +: 32] = 32'h4180_0000;
        tick();
        chk("post_grant", 32'(grant), 32'h4);
        req = '0;
        repeat (4) tick();
        tick();
        chk("post_done",   32'(done), 32'h4);
        chk("post_result", result,    32'h3E80_0000);

        // Randomized traffic honouring the hold-until-grant protocol
        hold = '0;
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < N; k++) begin
                if (!hold[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        hold[k] = 1'b1;
                        req[k]  = 1'b1;
                        operand[32*k +: 32] = rand_op();
                    end else begin
                        req[k] = 1'b0;
                        operand[32*k +: 32] = 32'($urandom);
                    end
                end
            end
            rst_n = (t == 200) ? 1'b0 : 1'b1;
            tick();
            if (!rst_n) hold = '0;
            else        hold = hold & ~e_grant;
        end
        rst_n = 1'b1;
        req   = '0;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
